ram_sdp_param: RTL and testbench



---
 rtl/ram_sdp_param_if.sv | 26 ++
 rtl/ram_sdp_param.sv | 156 +++++++++++++++
 tb/tb_ram_sdp_param.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/ram_sdp_param_if.sv
// Write/read port bundle for ram_sdp_param; master drives requests, slave is the RAM.
interface ram_sdp_param_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 4
) ();
  logic                    wr_en;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic [DATA_WIDTH/8-1:0] wr_be;
  logic                    rd_en;
  logic [ADDR_WIDTH-1:0]   rd_addr;
  logic [DATA_WIDTH-1:0]   rd_data;
  logic                    rd_valid;
  logic                    init_busy;
  logic                    req_err;

  modport master (
    output wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
    input  rd_data, rd_valid, init_busy, req_err
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
    output rd_data, rd_valid, init_busy, req_err
  );
endinterface

// File: rtl/ram_sdp_param.sv
// Simple-dual-port RAM with byte-enable writes, write-first read bypass and a post-reset clear sweep.
// Optional macro RAM_SDP_OUT_REG_EN adds one output pipeline stage (read latency 2).
//   state    | meaning
//   ST_CLEAR | sweeping INIT_VALUE into every word; user requests dropped and flagged
//   ST_READY | normal read/write operation until the next reset
module ram_sdp_param #(
  parameter int unsigned           DATA_WIDTH = 16,
  parameter int unsigned           ADDR_WIDTH = 4,
  parameter int unsigned           DEPTH      = 16,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  ram_sdp_param_if.slave  bus
);

  localparam int unsigned             BE_WIDTH  = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0]     DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0]   PTR_LAST  = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {
    ST_CLEAR,
    ST_READY
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_waddr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic [BE_WIDTH-1:0]     mem_wbe;
  logic                    rd_fire;
  logic                    err_d;
  logic                    wr_in_range;
  logic                    rd_in_range;
  logic [DATA_WIDTH-1:0]   rd_word;

  logic [DATA_WIDTH-1:0]   rd_data_q;
  logic                    rd_valid_q;
  logic                    req_err_q;

  assign wr_in_range = ({1'b0, bus.wr_addr} < DEPTH_EXT);
  assign rd_in_range = ({1'b0, bus.rd_addr} < DEPTH_EXT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    mem_we    = 1'b0;
    mem_waddr = ptr_q;
    mem_wdata = INIT_VALUE;
    mem_wbe   = '1;
    rd_fire   = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        mem_we = 1'b1;
        err_d  = bus.wr_en | bus.rd_en;
        if (ptr_q == PTR_LAST) begin
          state_d = ST_READY;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + ADDR_WIDTH'(1);
        end
      end
      ST_READY: begin
        mem_we    = bus.wr_en & wr_in_range;
        mem_waddr = bus.wr_addr;
        mem_wdata = bus.wr_data;
        mem_wbe   = bus.wr_be;
        rd_fire   = bus.rd_en;
        // out-of-range write and read in one cycle still raise a single pulse
        err_d     = (bus.wr_en & ~wr_in_range) | (bus.rd_en & ~rd_in_range);
      end
      default: begin
        state_d = ST_CLEAR;
        ptr_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int k = 0; k < BE_WIDTH; k++) begin
        if (mem_wbe[k]) begin
          mem_q[mem_waddr][8*k +: 8] <= mem_wdata[8*k +: 8];
        end
      end
    end
  end

  // Write-first: bytes being written this cycle to the read address come from wr_data.
  always_comb begin
    rd_word = '0;
    if (rd_in_range) begin
      rd_word = mem_q[bus.rd_addr];
      for (int k = 0; k < BE_WIDTH; k++) begin
        if (mem_we && (bus.wr_addr == bus.rd_addr) && bus.wr_be[k]) begin
          rd_word[8*k +: 8] = bus.wr_data[8*k +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      req_err_q  <= 1'b0;
    end else begin
      rd_valid_q <= rd_fire;
      req_err_q  <= err_d;
      if (rd_fire) begin
        rd_data_q <= rd_word;
      end
    end
  end

`ifdef RAM_SDP_OUT_REG_EN
  logic [DATA_WIDTH-1:0] out_data_q;
  logic                  out_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= rd_valid_q;
      if (rd_valid_q) begin
        out_data_q <= rd_data_q;
      end
    end
  end

  assign bus.rd_data  = out_data_q;
  assign bus.rd_valid = out_valid_q;
`else
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
`endif

  assign bus.req_err   = req_err_q;
  assign bus.init_busy = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_ram_sdp_param.sv
// Directed bench for ram_sdp_param: a 16-word instance and a 12-word instance for range errors.
module tb_ram_sdp_param;

`ifdef RAM_SDP_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk;
  logic rst1_n;
  logic rst2_n;
  int   n_checks;
  int   n_errors;
  int   busy_cnt;
  logic [15:0] b2b_val [4];

  ram_sdp_param_if #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) bus1 ();
  ram_sdp_param_if #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) bus2 ();

  ram_sdp_param #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .DEPTH(16), .INIT_VALUE(16'h0000)) dut1 (
    .clk   (clk),
    .rst_n (rst1_n),
    .bus   (bus1)
  );

  ram_sdp_param #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .DEPTH(12), .INIT_VALUE(16'h0000)) dut2 (
    .clk   (clk),
    .rst_n (rst2_n),
    .bus   (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr1(input logic [3:0] addr, input logic [15:0] data, input logic [1:0] be);
    bus1.wr_en   = 1'b1;
    bus1.wr_addr = addr;
    bus1.wr_data = data;
    bus1.wr_be   = be;
    tick();
    bus1.wr_en   = 1'b0;
  endtask

  task automatic rd1(input logic [3:0] addr, input logic [15:0] exp, input string tag);
    bus1.rd_en   = 1'b1;
    bus1.rd_addr = addr;
    tick();
    bus1.rd_en   = 1'b0;
    if (LAT == 2) tick();
    check({tag, "_valid"}, 32'(bus1.rd_valid), 32'd1);
    check({tag, "_data"}, 32'(bus1.rd_data), 32'(exp));
  endtask

  // Counts cycles with init_busy high after release; bounded so a stuck sweep still ends.
  task automatic count_busy(output int cnt);
    cnt = 0;
    while (bus1.init_busy === 1'b1 && cnt < 100) begin
      tick();
      cnt++;
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst1_n = 1'b0;
    rst2_n = 1'b0;
    bus1.wr_en = 1'b0; bus1.wr_addr = '0; bus1.wr_data = '0; bus1.wr_be = '0;
    bus1.rd_en = 1'b0; bus1.rd_addr = '0;
    bus2.wr_en = 1'b0; bus2.wr_addr = '0; bus2.wr_data = '0; bus2.wr_be = '0;
    bus2.rd_en = 1'b0; bus2.rd_addr = '0;
    tick();
    tick();

    check("rst_rd_data", 32'(bus1.rd_data), 32'h0);
    check("rst_rd_valid", 32'(bus1.rd_valid), 32'd0);
    check("rst_req_err", 32'(bus1.req_err), 32'd0);
    check("rst_init_busy", 32'(bus1.init_busy), 32'd1);

    // Release both; a write to addr 2 is attempted in clear cycle 3.
    rst1_n = 1'b1;
    rst2_n = 1'b1;
    busy_cnt = 0;
    while (bus1.init_busy === 1'b1 && busy_cnt < 100) begin
      bus1.wr_en   = (busy_cnt == 3);
      bus1.wr_addr = 4'd2;
      bus1.wr_data = 16'hBEEF;
      bus1.wr_be   = 2'b11;
      tick();
      if (busy_cnt == 3) begin
        check("clr_req_err_pulse", 32'(bus1.req_err), 32'd1);
        check("clr_no_rd_valid", 32'(bus1.rd_valid), 32'd0);
      end
      if (busy_cnt == 4) check("clr_req_err_end", 32'(bus1.req_err), 32'd0);
      busy_cnt++;
    end
    bus1.wr_en = 1'b0;
    check("clear_len", 32'(busy_cnt), 32'd16);

    for (int a = 0; a < 16; a++) begin
      rd1(4'(a), 16'h0000, $sformatf("clr_rd%0d", a));
    end

    // Byte-enable merge.
    wr1(4'd3, 16'hABCD, 2'b11);
    wr1(4'd3, 16'h1200, 2'b10);
    rd1(4'd3, 16'h12CD, "be_merge");
    tick();
    check("hold_valid", 32'(bus1.rd_valid), 32'd0);
    check("hold_data", 32'(bus1.rd_data), 32'h12CD);

    wr1(4'd3, 16'hFFFF, 2'b00);
    check("be0_no_err", 32'(bus1.req_err), 32'd0);
    rd1(4'd3, 16'h12CD, "be0_noop");

    // Write-first collision.
    wr1(4'd5, 16'h00FF, 2'b11);
    bus1.wr_en = 1'b1; bus1.wr_addr = 4'd5; bus1.wr_data = 16'hAA00; bus1.wr_be = 2'b10;
    bus1.rd_en = 1'b1; bus1.rd_addr = 4'd5;
    tick();
    bus1.wr_en = 1'b0;
    bus1.rd_en = 1'b0;
    if (LAT == 2) tick();
    check("coll_valid", 32'(bus1.rd_valid), 32'd1);
    check("coll_data", 32'(bus1.rd_data), 32'hAAFF);
    rd1(4'd5, 16'hAAFF, "coll_stored");

    // Independent ports: write 7 while reading 5.
    bus1.wr_en = 1'b1; bus1.wr_addr = 4'd7; bus1.wr_data = 16'h5A5A; bus1.wr_be = 2'b11;
    bus1.rd_en = 1'b1; bus1.rd_addr = 4'd5;
    tick();
    bus1.wr_en = 1'b0;
    bus1.rd_en = 1'b0;
    if (LAT == 2) tick();
    check("indep_data", 32'(bus1.rd_data), 32'hAAFF);
    rd1(4'd7, 16'h5A5A, "indep_wr");

    // Back-to-back reads.
    b2b_val[0] = 16'h0302; b2b_val[1] = 16'h0405; b2b_val[2] = 16'h1111; b2b_val[3] = 16'h2222;
    for (int i = 0; i < 4; i++) wr1(4'(i), b2b_val[i], 2'b11);
    for (int i = 0; i < 4 + LAT - 1; i++) begin
      bus1.rd_en   = (i < 4);
      bus1.rd_addr = 4'(i);
      tick();
      if (i >= LAT - 1) begin
        check($sformatf("b2b_valid%0d", i), 32'(bus1.rd_valid), 32'd1);
        check($sformatf("b2b_data%0d", i), 32'(bus1.rd_data), 32'(b2b_val[i - (LAT - 1)]));
      end
    end
    bus1.rd_en = 1'b0;
    tick();
    check("b2b_done", 32'(bus1.rd_valid), 32'd0);

    // Out-of-range on the 12-word instance.
    bus2.wr_en = 1'b1; bus2.wr_addr = 4'd4; bus2.wr_data = 16'h7777; bus2.wr_be = 2'b11;
    tick();
    bus2.wr_en = 1'b0;
    bus2.rd_en = 1'b1; bus2.rd_addr = 4'd4;
    tick();
    bus2.rd_en = 1'b0;
    check("d12_inr_err", 32'(bus2.req_err), 32'd0);
    if (LAT == 2) tick();
    check("d12_inr_data", 32'(bus2.rd_data), 32'h7777);

    bus2.rd_en = 1'b1; bus2.rd_addr = 4'd13;
    tick();
    bus2.rd_en = 1'b0;
    check("oor_rd_err", 32'(bus2.req_err), 32'd1);
    if (LAT == 2) tick();
    check("oor_rd_valid", 32'(bus2.rd_valid), 32'd1);
    check("oor_rd_data", 32'(bus2.rd_data), 32'h0);
    tick();
    check("oor_rd_err_end", 32'(bus2.req_err), 32'd0);

    bus2.wr_en = 1'b1; bus2.wr_addr = 4'd14; bus2.wr_data = 16'hFFFF; bus2.wr_be = 2'b11;
    bus2.rd_en = 1'b1; bus2.rd_addr = 4'd15;
    tick();
    bus2.wr_en = 1'b0;
    bus2.rd_en = 1'b0;
    check("oor_dual_err", 32'(bus2.req_err), 32'd1);
    tick();
    check("oor_dual_single", 32'(bus2.req_err), 32'd0);

    // Reset in the middle of a fresh sweep restarts it from word 0.
    rst1_n = 1'b0;
    tick();
    rst1_n = 1'b1;
    for (int c = 0; c < 7; c++) tick();
    rst1_n = 1'b0;
    #1;
    check("midrst_busy", 32'(bus1.init_busy), 32'd1);
    check("midrst_rd_data", 32'(bus1.rd_data), 32'h0);
    @(negedge clk);
    rst1_n = 1'b1;
    count_busy(busy_cnt);
    check("midrst_clear_len", 32'(busy_cnt), 32'd16);
    rd1(4'd3, 16'h0000, "midrst_rd3");
    rd1(4'd15, 16'h0000, "midrst_rd15");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
